// File: rtl/fp16_normalize.sv
// fp16 operand normalizer, fed by the fp16 special-value classifier.
// Turns class flags plus sign/exp/mant fields into an unpacked operand:
//   - an unbiased two's-complement exponent,
//   - an 11-bit significand with an explicit leading bit,
//   - a 3-bit class code.
// Subnormals are normalized one bit per enabled cycle in the SHIFT state.
// Optional macro FP16_NORM_DAZ_EN: subnormals are flushed to signed zero
// at accept, and SHIFT is never entered.
`timescale 1ns/1ps

module fp16_normalize #(
   parameter int unsigned EXP_W = 7,
   parameter int unsigned BIAS  = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_nan,
   input  logic             is_pinf,
   input  logic             is_ninf,
   input  logic             is_normal,
   input  logic             is_subnormal,
   input  logic             sign_in,
   input  logic [4:0]       exp_in,
   input  logic [9:0]       mant_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign_out,
   output logic [EXP_W-1:0] exp_out,
   output logic [10:0]      sig_out,
   output logic [2:0]       class_out
);

   localparam logic [2:0] CLS_ZERO   = 3'd0;
   localparam logic [2:0] CLS_NORMAL = 3'd1;
   localparam logic [2:0] CLS_SUB    = 3'd2;
   localparam logic [2:0] CLS_PINF   = 3'd3;
   localparam logic [2:0] CLS_NINF   = 3'd4;
   localparam logic [2:0] CLS_NAN    = 3'd5;

   typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

   state_e           r_state;
   logic             r_sign;
   logic [EXP_W-1:0] r_exp;
   logic [10:0]      r_sig;
   logic [2:0]       r_class;

   logic [EXP_W-1:0] w_exp_norm;
   logic [EXP_W-1:0] w_exp_inf;
   logic [EXP_W-1:0] w_exp_sub;
   logic [EXP_W-1:0] w_exp_dec;
   logic [10:0]      w_sig_shl;

   assign w_exp_norm = EXP_W'(exp_in) - EXP_W'(BIAS);
   assign w_exp_inf  = EXP_W'(16);
   assign w_exp_sub  = EXP_W'(1) - EXP_W'(BIAS);
   assign w_exp_dec  = r_exp - EXP_W'(1);
   assign w_sig_shl  = {r_sig[9:0], 1'b0};

   assign in_ready  = enable & (r_state == StIdle);
   assign out_valid = (r_state == StHold);
   assign sign_out  = r_sign;
   assign exp_out   = r_exp;
   assign sig_out   = r_sig;
   assign class_out = r_class;

   // Operand FSM: capture at accept, shift subnormals, hold until taken downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_sig   <= '0;
         r_class <= CLS_ZERO;
      end else if (enable) begin
         case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_sign  <= sign_in;
                  r_state <= StHold;
                  if (is_nan) begin
                     r_class <= CLS_NAN;
                     r_exp   <= w_exp_inf;
                     r_sig   <= {1'b0, mant_in};
                  end else if (is_pinf || is_ninf) begin
                     r_class <= is_pinf ? CLS_PINF : CLS_NINF;
                     r_exp   <= w_exp_inf;
                     r_sig   <= '0;
                  end else if (is_subnormal) begin
`ifdef FP16_NORM_DAZ_EN
                     r_class <= CLS_ZERO;
                     r_exp   <= '0;
                     r_sig   <= '0;
`else
                     // A zero mantissa would never reach a leading one; treat it as zero
                     if (mant_in == 10'd0) begin
                        r_class <= CLS_ZERO;
                        r_exp   <= '0;
                        r_sig   <= '0;
                     end else begin
                        r_class <= CLS_SUB;
                        r_exp   <= w_exp_sub;
                        r_sig   <= {1'b0, mant_in};
                        r_state <= StShift;
                     end
`endif
                  end else if (is_normal) begin
                     r_class <= CLS_NORMAL;
                     r_exp   <= w_exp_norm;
                     r_sig   <= {1'b1, mant_in};
                  end else begin
                     r_class <= CLS_ZERO;
                     r_exp   <= '0;
                     r_sig   <= '0;
                  end
               end
            end
            StShift: begin
               r_sig <= w_sig_shl;
               r_exp <= w_exp_dec;
               if (w_sig_shl[10]) begin
                  r_state <= StHold;
               end
            end
            StHold: begin
               if (out_ready) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
